// File: rtl/hvirq_sched.sv
// rtl/hvirq_sched.sv - VS-level interrupt scheduler with req/ack handshake and post-ack holdoff
// Picks the highest-priority deliverable VS interrupt and holds it until ack, flush or withdrawal.
module hvirq_sched #(
  parameter int          GEILEN  = 6,
  parameter int          HOLDOFF = 2,
  parameter logic [1:0]  U_MODE  = 2'b00,
  parameter logic [1:0]  S_MODE  = 2'b01
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic [11:0]       i_pending,
  input  logic [11:0]       i_hie,
  input  logic [11:0]       i_hideleg,
  input  logic [GEILEN:0]   i_hgeip,
  input  logic [GEILEN:0]   i_hgeie,
  input  logic [5:0]        i_vgein,
  input  logic              i_virt_mode,
  input  logic [1:0]        i_priv_mode,
  input  logic              i_vssie,
  input  logic              i_trap_ack,
  input  logic              i_flush,
  output logic              o_vs_int_req,
  output logic [3:0]        o_vs_int_cause,
  output logic              o_holdoff
);

  localparam int CW = (HOLDOFF > 0) ? $clog2(HOLDOFF + 1) : 1;

  localparam logic [3:0] CAUSE_SEI = 4'd9;
  localparam logic [3:0] CAUSE_SSI = 4'd1;
  localparam logic [3:0] CAUSE_STI = 4'd5;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_HOLD
  } state_t;

  state_t          r_state;
  logic [CW-1:0]   r_cnt;
  logic            r_req;
  logic [3:0]      r_cause;
  logic            r_hold;

  logic            w_gext;
  logic [11:0]     w_effp;
  logic            w_e10;
  logic            w_e2;
  logic            w_e6;
  logic            w_gen;
  logic            w_any;
  logic            w_still;
  logic [3:0]      w_win;

  // Compare against each legal index so VGEIN=0 or >GEILEN never selects a line.
  always_comb begin
    w_gext = 1'b0;
    for (int i = 1; i <= GEILEN; i++) begin
      if (i_vgein == 6'(i)) begin
        w_gext = i_hgeip[i] & i_hgeie[i];
      end
    end
  end

  assign w_effp = i_pending | {1'b0, w_gext, 10'b0};
  assign w_e10  = w_effp[10] & i_hie[10] & i_hideleg[10];
  assign w_e2   = w_effp[2]  & i_hie[2]  & i_hideleg[2];
  assign w_e6   = w_effp[6]  & i_hie[6]  & i_hideleg[6];
  assign w_any  = w_e10 | w_e2 | w_e6;
  assign w_gen  = i_virt_mode &
                  ((i_priv_mode == U_MODE) | ((i_priv_mode == S_MODE) & i_vssie));

  always_comb begin
    w_win = 4'd0;
    if (w_e10) begin
      w_win = CAUSE_SEI;
    end else if (w_e2) begin
      w_win = CAUSE_SSI;
    end else if (w_e6) begin
      w_win = CAUSE_STI;
    end
  end

  // Eligibility of the source already being presented, keyed by its latched cause.
  always_comb begin
    w_still = 1'b0;
    case (r_cause)
      CAUSE_SEI: w_still = w_e10;
      CAUSE_SSI: w_still = w_e2;
      CAUSE_STI: w_still = w_e6;
      default:   w_still = 1'b0;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= ST_IDLE;
      r_req   <= 1'b0;
      r_cause <= 4'd0;
      r_hold  <= 1'b0;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_gen && w_any) begin
            r_state <= ST_REQ;
            r_req   <= 1'b1;
            r_cause <= w_win;
          end
        end
        ST_REQ: begin
          if (i_trap_ack) begin
            r_req   <= 1'b0;
            r_cause <= 4'd0;
            if (HOLDOFF == 0) begin
              r_state <= ST_IDLE;
            end else begin
              r_state <= ST_HOLD;
              r_hold  <= 1'b1;
              r_cnt   <= CW'(HOLDOFF);
            end
          end else if (i_flush || !w_gen || !w_still) begin
            r_state <= ST_IDLE;
            r_req   <= 1'b0;
            r_cause <= 4'd0;
          end
        end
        ST_HOLD: begin
          r_cnt <= r_cnt - CW'(1);
          if (r_cnt <= CW'(1)) begin
            r_state <= ST_IDLE;
            r_hold  <= 1'b0;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_req   <= 1'b0;
          r_cause <= 4'd0;
          r_hold  <= 1'b0;
          r_cnt   <= '0;
        end
      endcase
    end
  end

  assign o_vs_int_req   = r_req;
  assign o_vs_int_cause = r_cause;
  assign o_holdoff      = r_hold;

endmodule

// File: tb/tb_hvirq_sched.sv
// tb/tb_hvirq_sched.sv - randomized and directed bench for hvirq_sched against a reference model
// Model tracks only "presenting cause X" and "holdoff cycles left", derived from the delivery rules.
module tb_hvirq_sched;

  localparam int GEILEN  = 6;
  localparam int HOLDOFF = 2;

  logic              clk = 1'b0;
  logic              reset;
  logic [11:0]       pending, hie, hideleg;
  logic [GEILEN:0]   hgeip, hgeie;
  logic [5:0]        vgein;
  logic              virt, vssie, ack, flush;
  logic [1:0]        priv;
  logic              o_req, o_hold;
  logic [3:0]        o_cause;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  bit m_req;
  int m_cause;
  int m_hold_left;

  always #5 clk = ~clk;

  hvirq_sched #(.GEILEN(GEILEN), .HOLDOFF(HOLDOFF)) dut (
    .i_clk          (clk),
    .i_reset        (reset),
    .i_pending      (pending),
    .i_hie          (hie),
    .i_hideleg      (hideleg),
    .i_hgeip        (hgeip),
    .i_hgeie        (hgeie),
    .i_vgein        (vgein),
    .i_virt_mode    (virt),
    .i_priv_mode    (priv),
    .i_vssie        (vssie),
    .i_trap_ack     (ack),
    .i_flush        (flush),
    .o_vs_int_req   (o_req),
    .o_vs_int_cause (o_cause),
    .o_holdoff      (o_hold)
  );

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic bit eligible(input int b);
    bit gext;
    bit p;
    gext = 1'b0;
    if (vgein >= 1 && vgein <= GEILEN) gext = hgeip[vgein] && hgeie[vgein];
    p = pending[b] || (b == 10 && gext);
    return p && hie[b] && hideleg[b];
  endfunction

  function automatic bit gen_ok();
    return virt && (priv == 2'd0 || (priv == 2'd1 && vssie));
  endfunction

  function automatic int winner();
    if (eligible(10)) return 9;
    if (eligible(2))  return 1;
    if (eligible(6))  return 5;
    return 0;
  endfunction

  function automatic int cause_bit(input int c);
    return (c == 9) ? 10 : (c == 1) ? 2 : 6;
  endfunction

  // Advance one clock with the current inputs, then compare against the model.
  task automatic step(input string tag);
    bit n_req;
    int n_cause, n_hold;
    n_req = m_req; n_cause = m_cause; n_hold = m_hold_left;
    if (reset) begin
      n_req = 0; n_cause = 0; n_hold = 0;
    end else if (m_hold_left > 0) begin
      n_hold = m_hold_left - 1;
    end else if (m_req) begin
      if (ack) begin
        n_req = 0; n_cause = 0; n_hold = HOLDOFF;
      end else if (flush || !gen_ok() || !eligible(cause_bit(m_cause))) begin
        n_req = 0; n_cause = 0;
      end
    end else if (gen_ok() && winner() != 0) begin
      n_req = 1; n_cause = winner();
    end
    @(posedge clk);
    #1;
    m_req = n_req; m_cause = n_cause; m_hold_left = n_hold;
    check({tag, ".req"},   int'(o_req),   int'(m_req));
    check({tag, ".cause"}, int'(o_cause), m_req ? m_cause : 0);
    check({tag, ".hold"},  int'(o_hold),  int'(m_hold_left > 0));
  endtask

  task automatic clear_inputs();
    pending = '0; hie = '0; hideleg = '0; hgeip = '0; hgeie = '0;
    vgein = '0; virt = 1'b0; priv = 2'd3; vssie = 1'b0; ack = 1'b0; flush = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step("rst");
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    clear_inputs();
    step("rst0");
    check("rst0.req_const", int'(o_req), 0);
    check("rst0.cause_const", int'(o_cause), 0);
    check("rst0.hold_const", int'(o_hold), 0);
    reset = 1'b0;

    // V=1, U-mode, SSIP and STIP eligible: SSI wins and stays stable
    virt = 1; priv = 2'd0;
    pending = 12'h044; hie = 12'h044; hideleg = 12'h044;
    step("d1.first");
    check("d1.cause1", int'(o_cause), 1);
    for (int i = 0; i < 5; i++) begin
      step("d1.hold");
      check("d1.stable", int'(o_cause), 1);
    end

    // STI presented, SEI arrives: no preemption; after ack and holdoff SEI is taken
    do_reset();
    pending = 12'h040; hie = 12'h440; hideleg = 12'h440;
    step("d2.sti");
    check("d2.cause5", int'(o_cause), 5);
    pending = 12'h440;
    step("d2.nopreempt");
    check("d2.still5", int'(o_cause), 5);
    ack = 1;
    step("d2.ack");
    ack = 0;
    check("d2.hold_a", int'(o_hold), 1);
    step("d2.hold2");
    check("d2.hold_b", int'(o_hold), 1);
    step("d2.idle");
    check("d2.idle_req", int'(o_req), 0);
    check("d2.idle_hold", int'(o_hold), 0);
    step("d2.sei");
    check("d2.cause9", int'(o_cause), 9);

    // Guest external line via VGEIN=3; out-of-range VGEIN=7 never requests
    do_reset();
    pending = '0; hie = 12'h400; hideleg = 12'h400;
    hgeip = 7'b0001000; hgeie = 7'b0001000; vgein = 6'd3;
    step("d3.gext");
    check("d3.cause9", int'(o_cause), 9);
    do_reset();
    hgeip = '1; hgeie = '1; vgein = 6'd7;
    for (int i = 0; i < 3; i++) begin
      step("d3.oor");
      check("d3.oor_req", int'(o_req), 0);
    end

    // Withdraw on enable clear; ack wins over flush
    do_reset();
    vgein = 0; pending = 12'h004; hie = 12'h004; hideleg = 12'h004;
    step("d4.req");
    hie = 12'h000;
    step("d4.withdraw");
    check("d4.withdrawn", int'(o_req), 0);
    hie = 12'h004;
    step("d4.rereq");
    ack = 1; flush = 1;
    step("d4.ackflush");
    ack = 0; flush = 0;
    check("d4.holdoff", int'(o_hold), 1);
    step("d4.h2");
    step("d4.h3");

    // Global-enable gating and reset mid-REQ
    do_reset();
    priv = 2'd1; vssie = 0;
    for (int i = 0; i < 2; i++) begin step("d5.s_noie"); check("d5.s_noie_req", int'(o_req), 0); end
    priv = 2'd0; virt = 0;
    for (int i = 0; i < 2; i++) begin step("d5.v0"); check("d5.v0_req", int'(o_req), 0); end
    virt = 1; priv = 2'd3;
    for (int i = 0; i < 2; i++) begin step("d5.m"); check("d5.m_req", int'(o_req), 0); end
    priv = 2'd1; vssie = 1;
    step("d5.s_ie");
    check("d5.s_ie_req", int'(o_req), 1);
    reset = 1;
    step("d5.rst");
    reset = 0;
    check("d5.rst_req", int'(o_req), 0);
    check("d5.rst_cause", int'(o_cause), 0);

    // Randomized traffic; enables drift slowly so requests live long enough to be acked
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 3) == 0) pending = 12'($urandom) & 12'h444;
      if ($urandom_range(0, 7) == 0) hie     = 12'($urandom) | (($urandom_range(0, 1) != 0) ? 12'h444 : 12'h000);
      if ($urandom_range(0, 7) == 0) hideleg = 12'($urandom) | (($urandom_range(0, 1) != 0) ? 12'h444 : 12'h000);
      if ($urandom_range(0, 7) == 0) begin hgeip = 7'($urandom); hgeie = 7'($urandom); end
      if ($urandom_range(0, 7) == 0) vgein = 6'($urandom_range(0, 9));
      if ($urandom_range(0, 15) == 0) virt = ($urandom_range(0, 5) != 0);
      if ($urandom_range(0, 15) == 0) priv = 2'($urandom);
      if ($urandom_range(0, 15) == 0) vssie = 1'($urandom);
      ack   = ($urandom_range(0, 3) == 0);
      flush = ($urandom_range(0, 9) == 0);
      reset = ($urandom_range(0, 99) == 0);
      step("rnd");
    end
    reset = 0; ack = 0; flush = 0;

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
